// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive blocks.
//   - uart_state_e : frame state encodings, prefixed so that uart_tx and uart_rx
//                    can import the same package without name clashes
//   - DEF_CLK_DIV  : default bit divider (bit period = DEF_CLK_DIV+1 clocks)
//   - DEF_WORD_LEN : default index of the last word bit (data plus parity)
//   - bit_period() : clocks per bit for a given divider
package uart_pkg;

  localparam int DEF_CLK_DIV  = 104;
  localparam int DEF_WORD_LEN = 8;

  typedef enum logic [2:0] {
    UART_IDLE      = 3'd0,
    UART_START     = 3'd1,
    UART_DATA      = 3'd2,
    UART_STOP      = 3'd3,
    UART_WAIT_HIGH = 3'd4
  } uart_state_e;

  function automatic int bit_period(input int clk_div);
    return clk_div + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous input.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, loads RESET_VAL into both flops
//   i_d     : asynchronous input
//   o_q     : synchronized output, two i_clk cycles of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      // stage p0: may go metastable; stage p1: settled copy
      meta_p0 <= i_d;
      sync_p1 <= meta_p0;
    end
  end

  assign o_q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, bit timing matched to uart_tx for direct loopback.
// Frame: start (0), p_WORD_LEN+1 word bits LSB first, stop (1).
//   i_clk       : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_rx        : serial line, asynchronous, idle high
//   o_data      : last correctly framed word, bit 0 received first
//   o_valid     : one-cycle strobe, o_data updated in the same cycle
//   o_frame_err : one-cycle strobe, stop bit sampled low
//   o_active    : high from start-bit qualification until the stop sample
module uart_rx
  import uart_pkg::*;
#(
  parameter int p_CLK_DIV  = DEF_CLK_DIV,
  parameter int p_WORD_LEN = DEF_WORD_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic [p_WORD_LEN:0]   o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_active
);

  localparam int CNT_W = $clog2(p_CLK_DIV + 1) + 1;
  localparam int BIT_W = $clog2(p_WORD_LEN + 1) + 1;
  localparam int HALF  = bit_period(p_CLK_DIV) / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(p_WORD_LEN);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic                 rx_s;
  logic                 rx_prev;
  logic                 rx_fall;
  uart_state_e          state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [p_WORD_LEN:0]  shreg;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // third flop: previous synchronized value for falling-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rx_prev <= 1'b1;
    else          rx_prev <= rx_s;
  end

  assign rx_fall = rx_prev & ~rx_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= UART_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_active    <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        UART_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (rx_fall) state <= UART_START;
        end
        UART_START: begin
          // re-check the line at the start-bit midpoint to reject glitches
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              o_active <= 1'b1;
              state    <= UART_DATA;
            end else begin
              state    <= UART_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        UART_DATA: begin
          // counting from the start midpoint lands every sample mid-bit;
          // shifting in at the MSB leaves the first bit in position 0
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[p_WORD_LEN:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= UART_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        UART_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            o_active <= 1'b0;
            if (rx_s) begin
              o_data  <= shreg;
              o_valid <= 1'b1;
              state   <= UART_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= UART_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        UART_WAIT_HIGH: begin
          // a held-low line (break) reports once, not as repeated frames
          if (rx_s) state <= UART_IDLE;
        end
        default: begin
          state    <= UART_IDLE;
          clk_cnt  <= '0;
          bit_cnt  <= '0;
          o_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLK_DIV  = 15;
  localparam int WORD_LEN = 8;
  localparam int PER      = CLK_DIV + 1;

  logic               clk;
  logic               rst_n;
  logic               rx;
  logic [WORD_LEN:0]  data;
  logic               valid;
  logic               ferr;
  logic               active;

  typedef struct packed {
    logic              is_err;
    logic [WORD_LEN:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   active_seen = 0;

  uart_rx #(
    .p_CLK_DIV  (CLK_DIV),
    .p_WORD_LEN (WORD_LEN)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pops the scoreboard whenever the receiver reports a frame
  always @(negedge clk) begin
    if (rst_n) begin
      if (active) active_seen = 1'b1;
      if (valid || ferr) begin
        checks++;
        if (valid && ferr) begin
          errors++;
          $display("FAIL pulse_overlap: valid=%0b frame_err=%0b, required at most one", valid, ferr);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%h, required no pulse", valid, ferr, data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_err !== ferr || e.data !== data) begin
            errors++;
            $display("FAIL frame_result: frame_err=%0b data=%h, required frame_err=%0b data=%h",
                     ferr, data, e.is_err, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [WORD_LEN:0] w, input logic stop, input int per);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i <= WORD_LEN; i++) begin
      rx = w[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_data",   32'(data),   0);
    check("reset_valid",  32'(valid),  0);
    check("reset_ferr",   32'(ferr),   0);
    check("reset_active", 32'(active), 0);
    rst_n = 1'b1;
    idle(10);

    // single frame
    exp_q.push_back('{is_err: 1'b0, data: 9'h1A5});
    send_frame(9'h1A5, 1'b1, PER);
    wait_drain("drain_single", 50);
    check("active_after_single", 32'(active), 0);
    idle(20);

    // back-to-back, no gap beyond the stop bit
    exp_q.push_back('{is_err: 1'b0, data: 9'h000});
    send_frame(9'h000, 1'b1, PER);
    exp_q.push_back('{is_err: 1'b0, data: 9'h1FF});
    send_frame(9'h1FF, 1'b1, PER);
    exp_q.push_back('{is_err: 1'b0, data: 9'h155});
    send_frame(9'h155, 1'b1, PER);
    wait_drain("drain_b2b", 50);
    idle(20);

    // short glitch must not start a frame
    active_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_active_seen", 32'(active_seen), 0);
    check("glitch_active", 32'(active), 0);

    // framing error with the line held low afterwards; o_data keeps 155
    exp_q.push_back('{is_err: 1'b1, data: 9'h155});
    send_frame(9'h0F0, 1'b0, PER);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    wait_drain("drain_ferr", 10);
    check("ferr_data_held", 32'(data), 32'h155);
    idle(40);

    // reset in the middle of data bit 4
    rx = 1'b0;
    repeat (PER) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(9'h0AA >> i);
      repeat (PER) @(negedge clk);
    end
    rx = 1'b0;
    repeat (PER / 2) @(negedge clk);
    check("midframe_active_before_reset", 32'(active), 1);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_data",   32'(data),   0);
    check("midframe_rst_valid",  32'(valid),  0);
    check("midframe_rst_ferr",   32'(ferr),   0);
    check("midframe_rst_active", 32'(active), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    exp_q.push_back('{is_err: 1'b0, data: 9'h03C});
    send_frame(9'h03C, 1'b1, PER);
    wait_drain("drain_after_reset", 50);
    idle(20);

    // transmitter running fast and slow
    exp_q.push_back('{is_err: 1'b0, data: 9'h1C3});
    send_frame(9'h1C3, 1'b1, PER - 1);
    idle(30);
    wait_drain("drain_fast", 50);
    exp_q.push_back('{is_err: 1'b0, data: 9'h1C3});
    send_frame(9'h1C3, 1'b1, PER + 1);
    idle(30);
    wait_drain("drain_slow", 50);
    check("final_active", 32'(active), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive stage; the downstream counterpart of the UART transmitter.
- Consumes the serial line and recovers the (p_WORD_LEN+1)-bit word (data plus parity, LSB first, start/stop framing).
- Presents the word with a one-cycle valid strobe and flags framing errors.
- Bit timing is identical to the transmitter so the two connect directly in loopback.

Parameters:
- p_CLK_DIV, 104: bit period is p_CLK_DIV+1 i_clk cycles, matching the transmitter.
- p_WORD_LEN, 8: index of the last word bit; p_WORD_LEN+1 bits are received per frame.

Ports:
- i_clk  input  1  system clock, all logic on its rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_rx  input  1  serial line, asynchronous to i_clk, idle high
- o_data  output  p_WORD_LEN+1  last good word; bit 0 is the first bit received after start
- o_valid  output  1  one-cycle pulse; o_data is updated in the same cycle
- o_frame_err  output  1  one-cycle pulse; stop bit was sampled low
- o_active  output  1  high from start-bit qualification until the frame ends

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0; synchronizer flops set to 1 (line idle).
- Reset asserted mid-frame aborts the frame with no valid or error pulse.
- Input: 2-flop synchronizer on i_rx to give rx_s; a third flop gives edge detection. All decisions use rx_s only.
- Widths: clock counter $clog2(p_CLK_DIV+1)+1 bits; bit counter $clog2(p_WORD_LEN+1)+1 bits; shift register p_WORD_LEN+1 bits.
- HALF = (p_CLK_DIV+1)/2, using integer division.
- IDLE: counters cleared. A falling edge on rx_s (previous 1, current 0) moves to START with clock count 0.
- START: count up to HALF-1, then sample rx_s.
  - rx_s==0: o_active<=1, clock count 0, go to DATA.
  - rx_s==1: glitch; return to IDLE with no outputs.
- DATA: count 0..p_CLK_DIV; on count==p_CLK_DIV, sample rx_s into bit position bit_count.
  - This is mid-bit, because the count starts from the start-bit midpoint.
  - After bit p_WORD_LEN, go to STOP; otherwise increment bit_count.
- STOP: count 0..p_CLK_DIV, then sample rx_s and set o_active<=0.
  - rx_s==1: o_data<=shift register, o_valid<=1, go to IDLE.
  - rx_s==0: o_frame_err<=1, o_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break or held-low line produces exactly one error, not repeated frames.
- o_valid and o_frame_err are high for exactly one cycle and are never high together.
- Latency:
  - o_valid rises 1 cycle after the stop-bit mid-sample.
  - The stop-bit mid-sample falls about (p_WORD_LEN+2)*(p_CLK_DIV+1)+HALF cycles after the start edge, plus 2-3 cycles of synchronizer delay.
- Back-to-back frames: returning to IDLE at mid-stop allows the next start edge to be caught immediately. No minimum idle time beyond the remaining half stop bit.
- Falling edges of rx_s during START/DATA/STOP do not restart the frame.
- Unused state encodings recover to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encodings for IDLE, START, DATA, STOP, WAIT_HIGH, so that uart_tx and uart_rx do not collide;
  - default p_CLK_DIV and p_WORD_LEN;
  - a bit-period helper constant.
- One natural sub-module: sync_2ff, a generic 2-flop synchronizer with a reset value parameter. It is reusable by other asynchronous inputs in the codebase.

Test Plan:
- Loopback, p_CLK_DIV=15, p_WORD_LEN=8: uart_tx sends 9'h1A5 -> one o_valid, o_data=9'h1A5, o_frame_err never high, o_active low afterwards.
- Back-to-back: uart_tx sends 9'h000, 9'h1FF, 9'h155 with i_send held high -> three o_valid pulses in order with those values, and no missed frames.
- Glitch: drive i_rx low for 4 cycles (< HALF=8), then high -> no o_active, no o_valid, state back to IDLE.
- Framing error: bit-bang start, data 9'h0F0, stop=0, then hold low for 100 cycles -> one o_frame_err pulse, o_data keeps its previous value, and no further pulses until the line returns high.
- Reset mid-frame: assert i_rst_n=0 during data bit 4 -> all outputs 0 immediately (async). The next clean frame 9'h03C is received correctly after release.
- Baud tolerance: bit-bang 9'h1C3 with bit period 15 and 17 cycles (±~6%) -> o_valid with o_data=9'h1C3 in both cases.
